// File: rtl/serial_add_core_pkg.sv
// Shared types and constants for the serial adder datapath (core and sum collector).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CARRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int COLLECT_W     = DEFAULT_WIDTH + 1;

endpackage

// File: rtl/serial_add_core_if.sv
// Command/operand/serial-output bundle of serial_add_core.
// sub_i exists only when SERIAL_SUB_EN is defined.
interface serial_add_core_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
`ifdef SERIAL_SUB_EN
    logic             sub_i;
`endif
    logic             sum_bit_o;
    logic             shift_en_o;
    logic             busy_o;
    logic             done_o;

`ifdef SERIAL_SUB_EN
    modport slave  (input  start_i, a_i, b_i, sub_i,
                    output sum_bit_o, shift_en_o, busy_o, done_o);
    modport master (output start_i, a_i, b_i, sub_i,
                    input  sum_bit_o, shift_en_o, busy_o, done_o);
`else
    modport slave  (input  start_i, a_i, b_i,
                    output sum_bit_o, shift_en_o, busy_o, done_o);
    modport master (output start_i, a_i, b_i,
                    input  sum_bit_o, shift_en_o, busy_o, done_o);
`endif

endinterface

// File: rtl/serial_add_core_fa_cell.sv
// Bit-serial full adder: combinational sum plus a carry flop with load and enable.
module serial_fa_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic init_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    logic carry_q;
    logic carry_d;

    assign sum_o   = a_i ^ b_i ^ carry_q;
    assign carry_o = carry_q;

    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = init_i;
        end else if (en_i) begin
            carry_d = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_core.sv
// LSB-first serial adder feeding a WIDTH+1 sum collector; final emitted bit is the carry-out.
// Optional SERIAL_SUB_EN adds sub_i for two's-complement A-B.
module serial_add_core
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    serial_add_core_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic             carry_load;
    logic             carry_en;
    logic             carry_init;
    logic             fa_sum;
    logic             carry_q;
    logic [WIDTH-1:0] b_load;

    logic sum_bit;
    logic shift_en;
    logic busy;
    logic done;

`ifdef SERIAL_SUB_EN
    // Subtract as A + ~B + 1: invert B and preload the carry.
    assign b_load     = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign carry_init = bus.sub_i;
`else
    assign b_load     = bus.b_i;
    assign carry_init = 1'b0;
`endif

    serial_fa_cell u_fa (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (carry_load),
        .init_i  (carry_init),
        .en_i    (carry_en),
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .sum_o   (fa_sum),
        .carry_o (carry_q)
    );

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        cnt_d      = cnt_q;
        carry_load = 1'b0;
        carry_en   = 1'b0;
        sum_bit    = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_sh_d     = bus.a_i;
                    b_sh_d     = b_load;
                    cnt_d      = '0;
                    carry_load = 1'b1;
                    state_d    = ADD;
                end
            end
            ADD: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                sum_bit  = fa_sum;
                carry_en = 1'b1;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = CARRY;
                end
            end
            CARRY: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                sum_bit  = carry_q;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum_bit_o  = sum_bit;
    assign bus.shift_en_o = shift_en;
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;

endmodule

// File: tb/tb_serial_add_core.sv
// Directed bench for serial_add_core with a behavioural 9-bit sum collector.
// Subtraction vectors run when SERIAL_SUB_EN is defined.
module tb_serial_add_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_core_if #(.WIDTH(W)) bus ();

    serial_add_core #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    // Downstream collector: shifts in from the MSB, so the first bit lands at bit 0.
    logic [W:0] coll;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= '0;
        end else if (bus.shift_en_o) begin
            coll <= {bus.sum_bit_o, coll[W:1]};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a start in IDLE; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            input bit hold);
        @(negedge clk);
        bus.a_i     = a;
        bus.b_i     = b;
`ifdef SERIAL_SUB_EN
        bus.sub_i   = sub;
`else
        if (sub) $display("note: sub requested without SERIAL_SUB_EN");
`endif
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start_i = 1'b0;
    endtask

    // Sample each cycle at negedge until done_o; bounded.
    task automatic wait_done(input bit scramble, output int cyc, output int shifts,
                             output int busys, output int overlaps);
        bit seen;
        seen = 0;
        cyc = 0; shifts = 0; busys = 0; overlaps = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.shift_en_o) shifts++;
            if (bus.busy_o) busys++;
            if (bus.busy_o && bus.done_o) overlaps++;
            if (bus.done_o) begin
                seen = 1;
                cyc  = i;
            end
            if (scramble) begin
                bus.a_i = W'($urandom);
                bus.b_i = W'($urandom);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done_o within 30 cycles expected a pulse");
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W:0] exp, input bit scramble);
        int cyc, sh, bz, ov;
        start_op(a, b, sub, 1'b0);
        wait_done(scramble, cyc, sh, bz, ov);
        check({tag, "_coll"}, 32'(coll), 32'(exp));
        check({tag, "_shifts"}, sh, W + 1);
        check({tag, "_busy"}, bz, W + 1);
        check({tag, "_donecyc"}, cyc, W + 2);
        check({tag, "_overlap"}, ov, 0);
    endtask

    initial begin
        int cyc, sh, bz, ov;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
`ifdef SERIAL_SUB_EN
        bus.sub_i   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_shift_en", 32'(bus.shift_en_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_sum", 32'(bus.sum_bit_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy_o), 0);

        run_op("add_5_3", 8'd5, 8'd3, 1'b0, 9'h008, 1'b0);
        run_op("add_255_1", 8'd255, 8'd1, 1'b0, 9'h100, 1'b0);
        run_op("add_255_255", 8'd255, 8'd255, 1'b0, 9'h1FE, 1'b0);
        run_op("add_scramble", 8'd100, 8'd200, 1'b0, 9'h12C, 1'b1);

        // start held high through the op and the done cycle
        start_op(8'd7, 8'd9, 1'b0, 1'b1);
        wait_done(1'b0, cyc, sh, bz, ov);
        check("hold_coll", 32'(coll), 32'h010);
        check("hold_donecyc", cyc, W + 2);
        check("hold_overlap", ov, 0);
        @(negedge clk);
        check("hold_idle_busy", 32'(bus.busy_o), 0);
        check("hold_idle_shift", 32'(bus.shift_en_o), 0);
        check("hold_idle_done", 32'(bus.done_o), 0);
        @(negedge clk);
        check("hold_restart_busy", 32'(bus.busy_o), 1);
        bus.start_i = 1'b0;
        wait_done(1'b0, cyc, sh, bz, ov);
        check("hold_second_coll", 32'(coll), 32'h010);
        check("hold_second_overlap", ov, 0);

        // asynchronous reset in cycle 4 of ADD
        start_op(8'd5, 8'd3, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_pre_busy", 32'(bus.busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_shift_en", 32'(bus.shift_en_o), 0);
        check("abort_busy", 32'(bus.busy_o), 0);
        check("abort_sum", 32'(bus.sum_bit_o), 0);
        ov = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o) ov++;
        end
        check("abort_no_done", ov, 0);
        rst_n = 1'b1;
        run_op("add_10_20", 8'd10, 8'd20, 1'b0, 9'h01E, 1'b0);

`ifdef SERIAL_SUB_EN
        run_op("sub_10_3", 8'd10, 8'd3, 1'b1, 9'h107, 1'b0);
        run_op("sub_3_10", 8'd3, 8'd10, 1'b1, 9'h0F9, 1'b0);
        run_op("sub0_add", 8'd3, 8'd10, 1'b0, 9'h00D, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_core.md
Name: serial_add_core

Overview:
- Upstream stage of the serial adder datapath.
- On a start command it latches two parallel operands and adds them LSB-first with a bit-serial full adder and a carry flip-flop.
- It emits one sum bit per cycle plus a shift-enable strobe that drive the downstream 9-bit sum collector's data_i/enable_i, then emits the final carry as the last (MSB) bit.
- A controller FSM sequences the WIDTH+1 shift cycles and reports busy/done to the system controller.

Parameters:
- WIDTH, 8, operand width. Downstream collector width is WIDTH+1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- a_i  input  WIDTH  operand A, latched when start is accepted.
- b_i  input  WIDTH  operand B, latched when start is accepted.
- sum_bit_o  output  1  serial sum bit, to collector data_i.
- shift_en_o  output  1  shift strobe, to collector enable_i.
- busy_o  output  1  high from the cycle after start acceptance until done_o is asserted, exclusive.
- done_o  output  1  one-cycle pulse after the last bit has shifted.

Behaviour:
- Reset (async, rst_i=0):
  - State = IDLE; shift registers, carry and counter are cleared.
  - All outputs are 0 while in reset and in IDLE.
- States: IDLE, ADD, CARRY, DONE. State, a_sh, b_sh, carry and cnt are registered. Outputs are decoded combinationally from registers only (Moore), so the collector samples a stable bit at the same edge.
- IDLE:
  - If start_i=1 at a rising edge: a_sh<=a_i, b_sh<=b_i, carry<=0, cnt<=0, next state ADD.
  - Otherwise stay in IDLE.
- ADD:
  - Outputs: shift_en_o=1, busy_o=1, sum_bit_o = a_sh[0]^b_sh[0]^carry.
  - At each edge: carry <= majority(a_sh[0], b_sh[0], carry); a_sh and b_sh shift right with zero fill; cnt++.
  - When cnt==WIDTH-1 at the edge, next state is CARRY. ADD therefore lasts exactly WIDTH cycles.
- CARRY:
  - Outputs: shift_en_o=1, busy_o=1, sum_bit_o=carry.
  - Next state DONE.
- DONE:
  - Outputs: done_o=1, shift_en_o=0, busy_o=0.
  - Next state IDLE unconditionally; start_i is ignored in this cycle.
- Timing: with start accepted at edge 0, sum bits 0..WIDTH-1 are presented in cycles 1..WIDTH and the carry in cycle WIDTH+1. done_o is high in cycle WIDTH+2. Earliest next start acceptance is at the end of the done cycle+1 (IDLE).
- shift_en_o is high for exactly WIDTH+1 consecutive cycles per operation, which fills the collector with {carry, sum[WIDTH-1:0]}.
- start_i while busy or in DONE is ignored; no queuing.
- Changes on a_i/b_i after acceptance have no effect.
- Reset mid-operation aborts immediately: outputs go to 0, no done pulse. The collector is reset by the same rst_i.
- cnt width is $clog2(WIDTH). WIDTH>=2 is required.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - Adds an input sub_i (1 bit), sampled together with start_i.
  - sub_i=1 at acceptance: b_sh<=~b_i and carry<=1, so the block computes A-B in two's complement.
  - The final emitted bit is the carry-out; 1 means no borrow (A>=B).
  - sub_i=0 behaves as plain add.
- Not defined: sub_i port is absent; add only.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum type (IDLE, ADD, CARRY, DONE);
  - default WIDTH constant;
  - COLLECT_W = WIDTH+1 constant, shared with the collector.
- One sub-module is natural: serial_fa_cell. It contains the combinational full adder plus the carry flop, with load (init value) and enable inputs. The FSM, shift registers and counter stay in serial_add_core.

Test Plan:
- a=5, b=3, start: shift_en high 9 cycles; bit sequence LSB-first 0,0,0,1,0,0,0,0 then carry 0 → collector 9'h008; done pulse in cycle 10.
- a=255, b=1 → collector 9'h100 (carry bit 1); a=255, b=255 → 9'h1FE.
- start_i held high across the entire operation and in the DONE cycle: exactly one operation; second operation begins only after return to IDLE; busy_o/done_o never overlap.
- rst_i dropped in cycle 4 of ADD: all outputs 0 asynchronously, no done pulse; next start with a=10, b=20 → 9'h01E.
- a_i/b_i changed every cycle during ADD: result equals the sum of the operands latched at acceptance.
- SERIAL_SUB_EN defined:
  - a=10, b=3, sub=1 → collector 9'h107;
  - a=3, b=10, sub=1 → 9'h0F9 (carry 0, i.e. borrow).
